// File: rtl/fb_double_buffer_if.sv
// Pixel-write, swap-control and scanout-read signals of the double-buffered frame buffer.
// The generator/scanout side uses master; the frame buffer uses slave.
interface fb_double_buffer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [7:0] wr_r;
    logic [7:0] wr_g;
    logic [7:0] wr_b;
    logic       swap_req;
    logic       swap_pending;
    logic       front_sel;
    logic       vblank;
    logic       rd_en;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       rd_valid;
    logic [7:0] rd_r;
    logic [7:0] rd_g;
    logic [7:0] rd_b;

    modport master (
        output wr_valid, wr_x, wr_y, wr_r, wr_g, wr_b, swap_req, vblank, rd_en, rd_x, rd_y,
        input  wr_ready, swap_pending, front_sel, rd_valid, rd_r, rd_g, rd_b
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_r, wr_g, wr_b, swap_req, vblank, rd_en, rd_x, rd_y,
        output wr_ready, swap_pending, front_sel, rd_valid, rd_r, rd_g, rd_b
    );
endinterface

// File: rtl/fb_double_buffer.sv
// Double-buffered frame buffer: pixel writes go to the back bank, scanout reads the front bank,
// and a requested swap waits for vblank and is followed by a clear of the new back bank.
module fb_double_buffer #(
    parameter int          FB_W        = 160,
    parameter int          FB_H        = 120,
    parameter int          SCALE_SHIFT = 2,
    parameter logic [23:0] CLEAR_RGB   = 24'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    fb_double_buffer_if.slave bus
);
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {CLEAR, WRITE, PEND} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_nxt;
    logic          front_sel, front_nxt;
    logic          wr_ready, swap_pending;
    logic          we_any;
    logic [AW-1:0] waddr;
    logic [23:0]   wdata;

    logic          pix_in;
    logic [AW-1:0] pix_addr;
    logic [9:0]    bx, by;
    logic          rd_in;
    logic [AW-1:0] raddr;

    logic [23:0]   bank0 [DEPTH];
    logic [23:0]   bank1 [DEPTH];
    logic [23:0]   q0, q1;
    logic          rd_valid, rd_sel, rd_oob;
    logic [23:0]   rd_word;

    assign pix_in   = (bus.wr_x < 10'(FB_W)) && (bus.wr_y < 10'(FB_H));
    assign pix_addr = AW'(bus.wr_y) * AW'(FB_W) + AW'(bus.wr_x);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            front_sel <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_nxt;
            front_sel <= front_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_nxt      = clr_cnt;
        front_nxt    = front_sel;
        wr_ready     = 1'b0;
        swap_pending = 1'b0;
        we_any       = 1'b0;
        waddr        = clr_cnt;
        wdata        = CLEAR_RGB;
        case (state)
            CLEAR: begin
                we_any = 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    clr_nxt   = '0;
                    state_nxt = WRITE;
                end else begin
                    clr_nxt = clr_cnt + AW'(1);
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                waddr    = pix_addr;
                wdata    = {bus.wr_r, bus.wr_g, bus.wr_b};
                we_any   = bus.wr_valid && pix_in;
                if (bus.swap_req) state_nxt = PEND;
            end
            PEND: begin
                swap_pending = 1'b1;
                if (bus.vblank) begin
                    front_nxt = ~front_sel;
                    clr_nxt   = '0;
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign bx    = bus.rd_x >> SCALE_SHIFT;
    assign by    = bus.rd_y >> SCALE_SHIFT;
    assign rd_in = (bx < 10'(FB_W)) && (by < 10'(FB_H));
    assign raddr = rd_in ? (AW'(by) * AW'(FB_W) + AW'(bx)) : '0;

    // One write port and one read port per bank; the back bank is the one not selected by front_sel.
    always_ff @(posedge clk) begin
        if (rst_n && we_any && front_sel) bank0[waddr] <= wdata;
        if (bus.rd_en) q0 <= bank0[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst_n && we_any && !front_sel) bank1[waddr] <= wdata;
        if (bus.rd_en) q1 <= bank1[raddr];
    end

    // Bank select and range flag are captured with the read so the output holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_sel   <= 1'b0;
            rd_oob   <= 1'b1;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel <= front_sel;
                rd_oob <= !rd_in;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (!rd_oob) rd_word = rd_sel ? q1 : q0;
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.swap_pending = swap_pending;
    assign bus.front_sel    = front_sel;
    assign bus.rd_valid     = rd_valid;
    assign bus.rd_r         = rd_word[23:16];
    assign bus.rd_g         = rd_word[15:8];
    assign bus.rd_b         = rd_word[7:0];
endmodule

// File: tb/tb_fb_double_buffer.sv
// Scoreboard bench for fb_double_buffer; FB_H is reduced to 30 rows so each clear is 4800 cycles.
module tb_fb_double_buffer;
    localparam int FB_W  = 160;
    localparam int FB_H  = 30;
    localparam int DEPTH = FB_W * FB_H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fb_double_buffer_if bus ();

    fb_double_buffer #(
        .FB_W       (FB_W),
        .FB_H       (FB_H),
        .SCALE_SHIFT(2),
        .CLEAR_RGB  (24'h000000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] m0 [int];
    logic [23:0] m1 [int];
    logic        fs;
    logic [23:0] exp_q [$];
    logic [23:0] last_rd;

    function automatic logic [23:0] get_px(logic b, int a);
        if (b == 1'b0) return m0.exists(a) ? m0[a] : 24'h0;
        return m1.exists(a) ? m1[a] : 24'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (bus.wr_ready !== 1'b1 && cyc <= DEPTH + 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic write_px(input int x, input int y, input logic [23:0] c);
        bus.wr_x = 10'(x);
        bus.wr_y = 10'(y);
        {bus.wr_r, bus.wr_g, bus.wr_b} = c;
        bus.wr_valid = 1'b1;
        if (bus.wr_ready === 1'b1 && x < FB_W && y < FB_H) begin
            if (fs) m0[y * FB_W + x] = c;
            else    m1[y * FB_W + x] = c;
        end
    endtask

    task automatic issue_read(input int x, input int y);
        int bx = x >> 2;
        int by = y >> 2;
        logic [23:0] e = (bx < FB_W && by < FB_H) ? get_px(fs, by * FB_W + bx) : 24'h0;
        exp_q.push_back(e);
        last_rd = e;
        bus.rd_x  = 10'(x);
        bus.rd_y  = 10'(y);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=1 with no read outstanding");
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({bus.rd_r, bus.rd_g, bus.rd_b} !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %06h expected %06h", {bus.rd_r, bus.rd_g, bus.rd_b}, e);
                end
            end
        end
    end

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.wr_ready, bus.front_sel, bus.swap_pending, bus.rd_valid} !== 4'b0000 ||
            {bus.rd_r, bus.rd_g, bus.rd_b} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/fs/pend/vld=%b rgb=%06h expected 0000 000000",
                     {bus.wr_ready, bus.front_sel, bus.swap_pending, bus.rd_valid}, {bus.rd_r, bus.rd_g, bus.rd_b});
        end
        rst_n = 1'b1;
        fs = 1'b0;
        m1.delete();
        wait_ready(cyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL reset_clear_len: wr_ready low %0d cycles expected %0d", cyc, DEPTH);
        end
        checks++;
        if ({bus.front_sel, bus.swap_pending} !== 2'b00) begin
            errors++;
            $display("FAIL reset_after_clear: fs/pend=%b expected 00", {bus.front_sel, bus.swap_pending});
        end
    endtask

    task automatic test_write_swap_read();
        int cyc;
        write_px(10, 20, {8'd66, 8'd233, 8'd245});
        tick();
        bus.wr_valid = 1'b0;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.swap_pending, bus.front_sel, bus.wr_ready} !== 3'b100) begin
            errors++;
            $display("FAIL pend_wait: pend/fs/rdy=%b expected 100", {bus.swap_pending, bus.front_sel, bus.wr_ready});
        end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        fs = 1'b1;
        m0.delete();
        checks++;
        if ({bus.front_sel, bus.swap_pending} !== 2'b10) begin
            errors++;
            $display("FAIL swap_vblank: fs/pend=%b expected 10", {bus.front_sel, bus.swap_pending});
        end
        wait_ready(cyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL swap_clear_len: clear took %0d cycles expected %0d", cyc, DEPTH);
        end
        issue_read(40, 80);
    endtask

    task automatic test_deferred_swap();
        int bad = 0;
        bus.vblank = 1'b0;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.front_sel !== fs || bus.wr_ready !== 1'b0 || bus.swap_pending !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL deferred_hold: %0d bad cycles expected 0", bad);
        end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        fs = ~fs;
        m1.delete();
        checks++;
        if ({bus.front_sel, bus.swap_pending, bus.wr_ready} !== {fs, 2'b00}) begin
            errors++;
            $display("FAIL deferred_swap: fs/pend/rdy=%b expected %b", {bus.front_sel, bus.swap_pending, bus.wr_ready}, {fs, 2'b00});
        end
    endtask

    task automatic test_clear_after_swap();
        int cyc;
        int seen = 0;
        write_px(10, 20, 24'h112233);
        for (int i = 0; i < 10; i++) begin
            if (bus.wr_ready !== 1'b0) seen++;
            tick();
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL clear_blocks_write: wr_ready high %0d cycles expected 0", seen);
        end
        issue_read(40, 80);
        wait_ready(cyc);
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: wr_ready=%b expected 1", bus.wr_ready);
        end
    endtask

    task automatic test_bounds();
        int cyc;
        logic rdy_oob;
        write_px(0, 1, 24'h123456);
        tick();
        write_px(160, 0, 24'hABCDEF);
        rdy_oob = bus.wr_ready;
        tick();
        write_px(0, FB_H, 24'h777777);
        tick();
        write_px(159, 0, 24'h0F1E2D);
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (rdy_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_accept: wr_ready=%b expected 1", rdy_oob);
        end
        bus.swap_req = 1'b1;
        bus.vblank = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        checks++;
        if ({bus.swap_pending, bus.front_sel} !== {1'b1, fs}) begin
            errors++;
            $display("FAIL pend_entry: pend/fs=%b expected %b", {bus.swap_pending, bus.front_sel}, {1'b1, fs});
        end
        tick();
        bus.vblank = 1'b0;
        fs = ~fs;
        if (fs) m0.delete(); else m1.delete();
        checks++;
        if ({bus.front_sel, bus.swap_pending} !== {fs, 1'b0}) begin
            errors++;
            $display("FAIL swap_on_entry: fs/pend=%b expected %b", {bus.front_sel, bus.swap_pending}, {fs, 1'b0});
        end
        issue_read(636, 0);
        issue_read(0, 0);
        issue_read(640, 0);
        issue_read(0, FB_H * 4);
        issue_read(0, 4);
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || {bus.rd_r, bus.rd_g, bus.rd_b} !== last_rd) begin
            errors++;
            $display("FAIL rd_hold: vld=%b rgb=%06h expected 0 %06h", bus.rd_valid, {bus.rd_r, bus.rd_g, bus.rd_b}, last_rd);
        end
        wait_ready(cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.vblank = 1'b0;
        write_px(50, 25, 24'h5A5A01);
        bus.swap_req = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        bus.swap_req = 1'b0;
        checks++;
        if ({bus.swap_pending, bus.front_sel} !== {1'b1, fs}) begin
            errors++;
            $display("FAIL second_req_pend: pend/fs=%b expected %b", {bus.swap_pending, bus.front_sel}, {1'b1, fs});
        end
        bus.vblank = 1'b1;
        tick();
        bus.vblank = 1'b0;
        fs = ~fs;
        if (fs) m0.delete(); else m1.delete();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        wait_ready(cyc);
        repeat (3) tick();
        checks++;
        if ({bus.front_sel, bus.swap_pending, bus.wr_ready} !== {fs, 2'b01}) begin
            errors++;
            $display("FAIL single_toggle: fs/pend/rdy=%b expected %b", {bus.front_sel, bus.swap_pending, bus.wr_ready}, {fs, 2'b01});
        end
        issue_read(200, 100);
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        bus.swap_req = 1'b1;
        bus.vblank = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        tick();
        bus.vblank = 1'b0;
        repeat (1000) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        fs = 1'b0;
        checks++;
        if ({bus.front_sel, bus.wr_ready, bus.rd_r, bus.rd_g, bus.rd_b} !== 26'h0) begin
            errors++;
            $display("FAIL mid_reset_state: fs=%b rdy=%b rgb=%06h expected 0 0 000000",
                     bus.front_sel, bus.wr_ready, {bus.rd_r, bus.rd_g, bus.rd_b});
        end
        wait_ready(cyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL mid_reset_clear_len: clear took %0d cycles expected %0d", cyc, DEPTH);
        end
        issue_read(640, 0);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_x = '0;
        bus.wr_y = '0;
        bus.wr_r = '0;
        bus.wr_g = '0;
        bus.wr_b = '0;
        bus.swap_req = 1'b0;
        bus.vblank = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_x = '0;
        bus.rd_y = '0;
        fs = 1'b0;
        last_rd = '0;
        test_reset();
        test_write_swap_read();
        test_deferred_swap();
        test_clear_after_swap();
        test_bounds();
        test_back_to_back();
        test_reset_mid_clear();
        tick();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rd_missing: %0d reads never returned rd_valid", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded 2 ms");
        $fatal(1, "watchdog");
    end
endmodule
